// File: rtl/fft_out_streamer.sv
// ---------------------------------------------------------------------------
// fft_out_streamer
//
// Purpose:
//     Takes the parallel result of an FFT core (NUM_POINTS complex words that
//     are valid for the single cycle i_done is high), holds it in a frame
//     buffer and streams it out one complex point per beat over a
//     valid/ready handshake. A frame that ends on the same cycle that the
//     next i_done arrives is followed by the next frame with no idle cycle.
//     An i_done that arrives while a frame is still being streamed is
//     dropped, and the sticky o_overrun flag records the drop.
//
// Configuration:
//     FFT_OUT_BITREV_EN  undefined (default): beats leave in natural order,
//                        beat k carries element k.
//                        defined: beat k carries element bitrev(k).
//
// Parameters:
//     NUM_POINTS  complex points per frame (power of two, >= 2)
//     SIZE_DATA   width of each real/imaginary word (carried opaquely)
//
// Ports:
//     i_clk          clock, rising edge
//     i_rst          synchronous active-high reset
//     i_done         one-cycle pulse, i_data_re/i_data_im valid on this cycle
//     i_data_re      parallel real results
//     i_data_im      parallel imaginary results
//     i_ready        downstream accepts the current beat
//     i_clr_overrun  clears o_overrun (a simultaneous set wins)
//     o_valid        current beat valid
//     o_data_re      real word of the current beat (0 when idle)
//     o_data_im      imaginary word of the current beat (0 when idle)
//     o_index        array index of the current beat (0 when idle)
//     o_last         final beat of the frame
//     o_busy         a frame is held or streaming (equals o_valid)
//     o_overrun      sticky: a frame was dropped
// ---------------------------------------------------------------------------
module fft_out_streamer #(
    parameter int NUM_POINTS = 8,
    parameter int SIZE_DATA  = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_done,
    input  logic [NUM_POINTS-1:0][SIZE_DATA-1:0]  i_data_re,
    input  logic [NUM_POINTS-1:0][SIZE_DATA-1:0]  i_data_im,
    input  logic                                  i_ready,
    input  logic                                  i_clr_overrun,
    output logic                                  o_valid,
    output logic [SIZE_DATA-1:0]                  o_data_re,
    output logic [SIZE_DATA-1:0]                  o_data_im,
    output logic [$clog2(NUM_POINTS)-1:0]         o_index,
    output logic                                  o_last,
    output logic                                  o_busy,
    output logic                                  o_overrun
);

    localparam int IDX_W = $clog2(NUM_POINTS);
    localparam logic [IDX_W-1:0] K_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] K_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_POINTS - 1);
    localparam logic [SIZE_DATA-1:0] D_ZERO = {SIZE_DATA{1'b0}};
    localparam logic [NUM_POINTS-1:0][SIZE_DATA-1:0] BUF_ZERO =
        {(NUM_POINTS*SIZE_DATA){1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Maps beat number to buffer element; identity unless bit-reversed
    // ordering is built in.
    function automatic logic [IDX_W-1:0] beat_sel(input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] r;
        r = k;
`ifdef FFT_OUT_BITREV_EN
        for (int b = 0; b < IDX_W; b++) begin
            r[b] = k[IDX_W-1-b];
        end
`endif
        return r;
    endfunction

    state_t                               state_r;
    state_t                               state_s;
    logic [IDX_W-1:0]                     k_r;
    logic [IDX_W-1:0]                     k_s;
    logic [NUM_POINTS-1:0][SIZE_DATA-1:0] buf_re_r;
    logic [NUM_POINTS-1:0][SIZE_DATA-1:0] buf_im_r;

    logic                                 xfer_s;
    logic                                 last_s;
    logic                                 load_s;
    logic                                 ovr_set_s;
    logic [IDX_W-1:0]                     sel_s;

    logic                                 valid_r;
    logic                                 valid_s;
    logic [SIZE_DATA-1:0]                 data_re_r;
    logic [SIZE_DATA-1:0]                 data_re_s;
    logic [SIZE_DATA-1:0]                 data_im_r;
    logic [SIZE_DATA-1:0]                 data_im_s;
    logic [IDX_W-1:0]                     index_r;
    logic [IDX_W-1:0]                     index_s;
    logic                                 last_out_r;
    logic                                 last_out_s;
    logic                                 overrun_r;
    logic                                 overrun_s;

    assign xfer_s = (state_r == ST_STREAM) && i_ready;
    assign last_s = (k_r == K_LAST);

    // Next-state, beat counter, frame capture and overrun detection.
    always_comb begin
        state_s   = state_r;
        k_s       = k_r;
        load_s    = 1'b0;
        ovr_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_done) begin
                    load_s  = 1'b1;
                    k_s     = K_ZERO;
                    state_s = ST_STREAM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (xfer_s && last_s) begin
                    // Final handshake: a coincident i_done chains the next
                    // frame without a bubble.
                    k_s = K_ZERO;
                    if (i_done) begin
                        load_s  = 1'b1;
                        state_s = ST_STREAM;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    if (xfer_s) begin
                        k_s = k_r + K_ONE;
                    end else begin
                        k_s = k_r;
                    end
                    // Any other i_done while streaming is a dropped frame.
                    ovr_set_s = i_done;
                end
            end
            default: begin
                state_s = ST_IDLE;
                k_s     = K_ZERO;
            end
        endcase
    end

    // Next values of the registered beat outputs and the overrun flag.
    always_comb begin
        sel_s      = beat_sel(k_s);
        valid_s    = 1'b0;
        data_re_s  = D_ZERO;
        data_im_s  = D_ZERO;
        index_s    = K_ZERO;
        last_out_s = 1'b0;
        overrun_s  = overrun_r;
        if (state_s == ST_STREAM) begin
            valid_s    = 1'b1;
            index_s    = sel_s;
            last_out_s = (k_s == K_LAST);
            // On a capture the buffer is not yet written, so the first beat
            // is taken straight from the input bus.
            if (load_s) begin
                data_re_s = i_data_re[sel_s];
                data_im_s = i_data_im[sel_s];
            end else begin
                data_re_s = buf_re_r[sel_s];
                data_im_s = buf_im_r[sel_s];
            end
        end else begin
            valid_s    = 1'b0;
            data_re_s  = D_ZERO;
            data_im_s  = D_ZERO;
            index_s    = K_ZERO;
            last_out_s = 1'b0;
        end
        if (ovr_set_s) begin
            overrun_s = 1'b1;
        end else if (i_clr_overrun) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end
    end

    // State register and beat counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            k_r     <= K_ZERO;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
        end
    end

    // Frame buffer, written only when a frame is captured.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            buf_re_r <= BUF_ZERO;
            buf_im_r <= BUF_ZERO;
        end else if (load_s) begin
            buf_re_r <= i_data_re;
            buf_im_r <= i_data_im;
        end else begin
            buf_re_r <= buf_re_r;
            buf_im_r <= buf_im_r;
        end
    end

    // Registered beat outputs and sticky overrun flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_r    <= 1'b0;
            data_re_r  <= D_ZERO;
            data_im_r  <= D_ZERO;
            index_r    <= K_ZERO;
            last_out_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            valid_r    <= valid_s;
            data_re_r  <= data_re_s;
            data_im_r  <= data_im_s;
            index_r    <= index_s;
            last_out_r <= last_out_s;
            overrun_r  <= overrun_s;
        end
    end

    assign o_valid   = valid_r;
    assign o_busy    = valid_r;
    assign o_data_re = data_re_r;
    assign o_data_im = data_im_r;
    assign o_index   = index_r;
    assign o_last    = last_out_r;
    assign o_overrun = overrun_r;

endmodule

// File: tb/tb_fft_out_streamer.sv
// ---------------------------------------------------------------------------
// tb_fft_out_streamer
//
// Scoreboard bench for fft_out_streamer (NUM_POINTS=8, SIZE_DATA=32).
// The driver issues one cycle of stimulus per call of step(); after the
// clock edge it updates a frame-level model: an accepted i_done appends the
// whole frame's beats (in beat order) to exp_q, a dropped one sets the
// expected overrun flag. The monitor, on every falling edge, compares the
// DUT outputs with the head of exp_q and pops it when the beat transfers.
// ---------------------------------------------------------------------------
module tb_fft_out_streamer;

    localparam int N  = 8;
    localparam int LG = 3;
    localparam int SD = 32;

    typedef struct {
        logic [SD-1:0] re;
        logic [SD-1:0] im;
        int            idx;
        bit            last;
    } beat_t;

    logic                   clk;
    logic                   i_rst;
    logic                   i_done;
    logic [N-1:0][SD-1:0]   i_data_re;
    logic [N-1:0][SD-1:0]   i_data_im;
    logic                   i_ready;
    logic                   i_clr_overrun;
    logic                   o_valid;
    logic [SD-1:0]          o_data_re;
    logic [SD-1:0]          o_data_im;
    logic [LG-1:0]          o_index;
    logic                   o_last;
    logic                   o_busy;
    logic                   o_overrun;

    beat_t exp_q[$];
    bit    exp_ovr;
    bit    mon_en;
    bit    use_pattern;
    int    n_checks;
    int    n_fail;

    fft_out_streamer #(.NUM_POINTS(N), .SIZE_DATA(SD)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_done        (i_done),
        .i_data_re     (i_data_re),
        .i_data_im     (i_data_im),
        .i_ready       (i_ready),
        .i_clr_overrun (i_clr_overrun),
        .o_valid       (o_valid),
        .o_data_re     (o_data_re),
        .o_data_im     (o_data_im),
        .o_index       (o_index),
        .o_last        (o_last),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Element presented on beat k.
    function automatic int beat_elem(input int k);
        int r;
        r = k;
`ifdef FFT_OUT_BITREV_EN
        r = 0;
        for (int b = 0; b < LG; b++) begin
            r = r * 2 + ((k >> b) & 1);
        end
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One cycle of stimulus, then the model update for that clock edge.
    task automatic step(input bit done, input bit ready, input bit clr, input bit rst);
        int    sz;
        beat_t b;
        logic [SD-1:0] fre [N];
        logic [SD-1:0] fim [N];
        i_done        = done;
        i_ready       = ready;
        i_clr_overrun = clr;
        i_rst         = rst;
        for (int n = 0; n < N; n++) begin
            if (use_pattern) begin
                fre[n] = SD'(n);
                fim[n] = SD'(32'h100 + n);
            end else begin
                fre[n] = $urandom();
                fim[n] = $urandom();
            end
            i_data_re[n] = fre[n];
            i_data_im[n] = fim[n];
        end
        sz = exp_q.size();
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            exp_ovr = 1'b0;
        end else if (done && (sz == 0 || (sz == 1 && ready))) begin
            for (int k = 0; k < N; k++) begin
                b.idx  = beat_elem(k);
                b.re   = fre[b.idx];
                b.im   = fim[b.idx];
                b.last = (k == N - 1);
                exp_q.push_back(b);
            end
            if (clr) exp_ovr = 1'b0;
        end else if (done) begin
            exp_ovr = 1'b1;
        end else if (clr) begin
            exp_ovr = 1'b0;
        end
    endtask

    // Monitor: compare DUT outputs with the scoreboard every cycle.
    always @(negedge clk) begin : monitor
        beat_t b;
        if (mon_en) begin
            chk("valid", 64'(o_valid), 64'(exp_q.size() != 0));
            chk("busy", 64'(o_busy), 64'(exp_q.size() != 0));
            chk("overrun", 64'(o_overrun), 64'(exp_ovr));
            if (exp_q.size() != 0) begin
                b = exp_q[0];
                chk("data_re", 64'(o_data_re), 64'(b.re));
                chk("data_im", 64'(o_data_im), 64'(b.im));
                chk("index", 64'(o_index), 64'(b.idx));
                chk("last", 64'(o_last), 64'(b.last));
                if (i_ready) void'(exp_q.pop_front());
            end else begin
                chk("idle_re", 64'(o_data_re), 64'd0);
                chk("idle_im", 64'(o_data_im), 64'd0);
                chk("idle_index", 64'(o_index), 64'd0);
                chk("idle_last", 64'(o_last), 64'd0);
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_ovr     = 1'b0;
        mon_en      = 1'b0;
        use_pattern = 1'b0;

        // Reset
        step(1'b0, 1'b1, 1'b0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Pattern frame, ready held high
        use_pattern = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        use_pattern = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Ready toggling 1,0,0,1,...
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, (i % 3) == 0, 1'b0, 1'b0);

        // Back-to-back frames: second i_done on the last handshake
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Overrun: i_done during beat 3, then clear
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // Overrun set and clear in the same cycle: set wins
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // Reset at beat 5, then a fresh frame
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(5, 0) == 0,
                 $urandom_range(3, 0) != 0,
                 $urandom_range(19, 0) == 0,
                 $urandom_range(299, 0) == 0);
        end

        // Drain
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("drained_valid", 64'(o_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_out_streamer.md
FFT_OUT_STREAMER -- requirements
Module: fft_out_streamer

Interface
REQ-001 The module SHALL have parameter NUM_POINTS, default 8, giving the number of complex points per frame; it must be a power of two and at least 2.
REQ-002 The module SHALL have parameter SIZE_DATA, default 32, giving the width in bits of each real or imaginary word (IEEE 754 single-precision, carried opaquely).
REQ-003 Port i_clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-004 Port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port i_done, input, 1 bit: single-cycle pulse from the FFT core; result words are valid on this cycle.
REQ-006 Port i_data_re, input, [NUM_POINTS-1:0][SIZE_DATA-1:0]: parallel real results.
REQ-007 Port i_data_im, input, [NUM_POINTS-1:0][SIZE_DATA-1:0]: parallel imaginary results.
REQ-008 Port i_ready, input, 1 bit: downstream accepts the current beat.
REQ-009 Port i_clr_overrun, input, 1 bit: clears o_overrun.
REQ-010 Port o_valid, output, 1 bit: the current beat is valid.
REQ-011 Port o_data_re, output, SIZE_DATA bits: real word of the current beat.
REQ-012 Port o_data_im, output, SIZE_DATA bits: imaginary word of the current beat.
REQ-013 Port o_index, output, $clog2(NUM_POINTS) bits: array index of the current beat.
REQ-014 Port o_last, output, 1 bit: the current beat is the final beat of the frame.
REQ-015 Port o_busy, output, 1 bit: a frame is held or being streamed.
REQ-016 Port o_overrun, output, 1 bit: sticky flag; a frame was dropped.

Function
REQ-017 The module SHALL implement a two-state FSM: IDLE and STREAM.
REQ-018 In IDLE, i_done=1 SHALL capture all 2*NUM_POINTS words into an internal frame buffer, clear beat counter k to 0, and enter STREAM on the next cycle.
REQ-019 o_valid SHALL be 1 exactly when in STREAM; first o_valid is the cycle after i_done (latency 1).
REQ-020 A beat transfers when o_valid and i_ready are both 1; each transfer increments k by 1.
REQ-021 While o_valid=1 and i_ready=0, o_data_re, o_data_im, o_index, and o_last SHALL hold stable.
REQ-022 o_last SHALL be 1 when in STREAM and k==NUM_POINTS-1.
REQ-023 A transfer with o_last=1 and i_done=0 SHALL return the FSM to IDLE, with o_valid=0 on the next cycle.
REQ-024 A transfer with o_last=1 and i_done=1 in the same cycle SHALL capture the new frame, reset k to 0, and remain in STREAM (back-to-back, no bubble).
REQ-025 i_done=1 in STREAM other than the case in REQ-024 SHALL be ignored for data; the held frame is unchanged, and o_overrun is set on the next cycle.
REQ-026 o_overrun SHALL be cleared by i_clr_overrun=1; if set and clear occur in the same cycle, set wins.
REQ-027 o_busy SHALL equal o_valid.
REQ-028 With i_ready held at 1, a frame SHALL take exactly NUM_POINTS cycles; sustained throughput is one frame per NUM_POINTS cycles.
REQ-029 o_data_re, o_data_im, and o_index SHALL be 0 whenever o_valid=0.

Reset
REQ-030 i_rst=1 at a rising edge SHALL force IDLE, k=0, o_valid=0, o_last=0, o_busy=0, o_overrun=0, o_index=0, o_data_re=0, o_data_im=0, and clear the frame buffer.
REQ-031 Reset mid-frame SHALL discard the frame with no further beats; reset has priority over i_done and i_clr_overrun.

Configuration
REQ-032 Macro FFT_OUT_BITREV_EN SHALL select the beat ordering; it is undefined by default.
REQ-033 With FFT_OUT_BITREV_EN undefined, beat k SHALL present buffer element k, with o_index=k (natural order).
REQ-034 With FFT_OUT_BITREV_EN defined, beat k SHALL present buffer element bitrev(k) over $clog2(NUM_POINTS) bits, with o_index=bitrev(k). For NUM_POINTS=8 the order is 0,4,2,6,1,5,3,7.
REQ-035 Handshake, latency, and flag behaviour SHALL be identical in both configurations.

Verification
REQ-036 Frame re[n]=n, im[n]=0x100+n; pulse i_done; i_ready=1 -> 8 beats on consecutive cycles starting 1 cycle later, o_index 0..7 (or 0,4,2,6,1,5,3,7 with FFT_OUT_BITREV_EN), o_last only on the 8th beat.
REQ-037 i_ready toggled 1,0,0,1,... during a frame -> no beat lost or duplicated; outputs stable during every stall.
REQ-038 Second i_done on the cycle of the last handshake -> 16 contiguous beats with no gap; o_overrun stays 0.
REQ-039 i_done at beat 3 of a frame -> the remainder of the first frame is unchanged, o_overrun=1 next cycle, FSM returns to IDLE after the beat with o_index 7; i_clr_overrun then clears the flag.
REQ-040 i_rst=1 at beat 5 -> o_valid=0 next cycle, all outputs 0; a new i_done afterwards streams from k=0.
